// File: rtl/operand_triple_loader_pkg.sv
// Shared types for the operand triple loader: FSM state encoding and counter width.
package operand_loader_pkg;

  typedef enum logic [1:0] {IDLE, HAVE_A, HAVE_B, FULL} loader_state_t;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/operand_triple_loader_if.sv
// Serial operand stream in, parallel a/b/c triple out, both with valid/ready handshakes.
interface operand_triple_loader_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_a, out_b, out_c, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_a, out_b, out_c, out_valid
  );
endinterface

// File: rtl/operand_triple_loader.sv
// Gathers three serial words (a, b, c) into one parallel triple for the AND stage.
// Optional OPERAND_TRIPLE_LOADER_CNT_EN adds a wrapping 16-bit transfer counter port.
module operand_triple_loader
  import operand_loader_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  operand_triple_loader_if.slave bus
`ifdef OPERAND_TRIPLE_LOADER_CNT_EN
  ,
  output logic [CNT_W-1:0]       triple_count
`endif
);

  loader_state_t    r_state;
  loader_state_t    w_state_nxt;
  logic [WIDTH-1:0] r_slot_a;
  logic [WIDTH-1:0] r_slot_b;
  logic [WIDTH-1:0] r_slot_c;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_xfer;
  logic             w_ld_a;
  logic             w_ld_b;
  logic             w_ld_c;

  always_comb begin
    w_in_ready  = (r_state != FULL) || bus.out_ready;
    w_accept    = bus.in_valid && w_in_ready;
    w_xfer      = (r_state == FULL) && bus.out_ready;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_ld_c      = 1'b0;
    w_state_nxt = r_state;
    // clear wins over any accept/transfer; the shown in_ready word is dropped
    if (clear) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          w_ld_a      = 1'b1;
          w_state_nxt = HAVE_A;
        end
        HAVE_A: if (w_accept) begin
          w_ld_b      = 1'b1;
          w_state_nxt = HAVE_B;
        end
        HAVE_B: if (w_accept) begin
          w_ld_c      = 1'b1;
          w_state_nxt = FULL;
        end
        FULL: if (w_xfer) begin
          w_ld_a      = w_accept;
          w_state_nxt = w_accept ? HAVE_A : IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_a <= '0;
      r_slot_b <= '0;
      r_slot_c <= '0;
    end else begin
      if (w_ld_a) r_slot_a <= bus.in_data;
      if (w_ld_b) r_slot_b <= bus.in_data;
      if (w_ld_c) r_slot_c <= bus.in_data;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_state == FULL);
  assign bus.out_a     = r_slot_a;
  assign bus.out_b     = r_slot_b;
  assign bus.out_c     = r_slot_c;

`ifdef OPERAND_TRIPLE_LOADER_CNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_xfer && !clear) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign triple_count = r_count;
`endif

endmodule

// File: tb/tb_operand_triple_loader.sv
// Randomised and directed checks of operand_triple_loader against a queue-based word model.
module tb_operand_triple_loader;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;

  operand_triple_loader_if #(.WIDTH(WIDTH)) bus ();

`ifdef OPERAND_TRIPLE_LOADER_CNT_EN
  logic [15:0] triple_count;
  operand_triple_loader #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus), .triple_count(triple_count)
  );
`else
  operand_triple_loader #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model: words accepted since the last transfer/clear/reset; three of them form the held triple.
  logic [WIDTH-1:0] pend[$];
  int               xfer_cyc[$];
  int               cyc = 0;
  logic [15:0]      m_count = '0;
  logic [WIDTH-1:0] got_a, got_b, got_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit ordy, input bit clr);
    int  n;
    bit  rdy;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    clear         = clr;
    #1;
    n   = pend.size();
    rdy = (n < 3) || ordy;
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, rdy});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, n == 3});
    if (n == 3) begin
      chk("out_a", 32'(bus.out_a), 32'(pend[0]));
      chk("out_b", 32'(bus.out_b), 32'(pend[1]));
      chk("out_c", 32'(bus.out_c), 32'(pend[2]));
    end
`ifdef OPERAND_TRIPLE_LOADER_CNT_EN
    chk("triple_count", 32'(triple_count), 32'(m_count));
`endif
    if (clr) begin
      pend.delete();
    end else begin
      if (n == 3 && ordy) begin
        got_a = bus.out_a;
        got_b = bus.out_b;
        got_c = bus.out_c;
        pend.delete();
        xfer_cyc.push_back(cyc);
        m_count = m_count + 16'd1;
      end
      if (v && rdy) pend.push_back(d);
    end
    cyc++;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_a", 32'(bus.out_a), 32'd0);
    chk("rst_out_b", 32'(bus.out_b), 32'd0);
    chk("rst_out_c", 32'(bus.out_c), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single triple
    step(1, 8'hF0, 1, 0);
    step(1, 8'hCC, 1, 0);
    step(1, 8'hAA, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("and_result", 32'(got_a & got_b & got_c), 32'h80);

    // Backpressure, then transfer with simultaneous capture of the next a
    step(1, 8'h3C, 0, 0);
    step(1, 8'h5A, 0, 0);
    step(1, 8'hC3, 0, 0);
    repeat (5) step(1, 8'h11, 0, 0);
    step(1, 8'h11, 1, 0);
    step(1, 8'h22, 1, 0);
    step(1, 8'h33, 1, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    chk("bp_next_a", 32'(got_a), 32'h11);

    // Streaming: 4 triples back-to-back
    xfer_cyc.delete();
    for (int i = 0; i < 12; i++) step(1, WIDTH'(8'h40 + i), 1, 0);
    step(0, 8'h00, 1, 0);
    chk("stream_count", 32'(xfer_cyc.size()), 32'd4);
    for (int i = 1; i < xfer_cyc.size(); i++)
      chk("stream_gap", 32'(xfer_cyc[i] - xfer_cyc[i-1]), 32'd3);
    chk("stream_last_c", 32'(got_c), 32'h4B);

    // Clear mid-triple discards the word shown alongside it
    step(1, 8'h01, 1, 0);
    step(1, 8'h02, 1, 0);
    step(1, 8'h03, 1, 1);
    step(1, 8'h04, 1, 0);
    step(1, 8'h05, 1, 0);
    step(1, 8'h06, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("clr_a", 32'(got_a), 32'h04);
    chk("clr_c", 32'(got_c), 32'h06);

    // Asynchronous reset while holding a and b
    step(1, 8'h5A, 1, 0);
    step(1, 8'h6B, 1, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_a", 32'(bus.out_a), 32'd0);
    chk("arst_out_b", 32'(bus.out_b), 32'd0);
    pend.delete();
    m_count = '0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step(1, 8'h77, 1, 0);
    step(1, 8'h88, 1, 0);
    step(1, 8'h99, 1, 0);
    step(0, 8'h00, 1, 0);
    chk("arst_first_a", 32'(got_a), 32'h77);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, WIDTH'($urandom), ($urandom % 3) != 0, ($urandom % 25) == 0);
    step(0, 8'h00, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
